// File: rtl/frame_buf_pkg.sv
// ---------------------------------------------------------------------------
// frame_buf_pkg : shared frame-buffer state encoding and default sizes (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package frame_buf_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_BUF_SIZE   = 5;
   localparam int DEF_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo : single-clock registered FIFO with occupancy count (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo
   import frame_buf_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic [CNT_W-1:0]      count,
   output logic                  full,
   output logic                  empty
);

   localparam int              PTR_W   = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      cnt;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (cnt == DEPTH_C);
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   // Head reads as zero when empty so the stream output is clean out of reset.
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/frame_rd_stream.sv
// ---------------------------------------------------------------------------
// frame_rd_stream : credit-limited frame reader streaming through a FIFO (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module frame_rd_stream
   import frame_buf_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int BUF_SIZE   = DEF_BUF_SIZE,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  rd_rdy,
   output logic                  rd_en_in,
   input  logic                  rd_data_valid,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int RC_W = $clog2(BUF_SIZE + 1);
   localparam int FC_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [RC_W-1:0] BUF_FULL = RC_W'(BUF_SIZE);
   localparam logic [RC_W-1:0] BUF_LAST = RC_W'(BUF_SIZE - 1);
   localparam logic [FC_W:0]   DEPTH_C  = (FC_W + 1)'(FIFO_DEPTH);

   state_t            state;
   state_t            state_nxt;
   logic [RC_W-1:0]   req_cnt;
   logic [RC_W-1:0]   out_cnt;
   logic [FC_W-1:0]   outstanding;
   logic [FC_W-1:0]   fifo_count;
   logic [FC_W:0]     credit_used;
   logic              credit_ok;
   logic              fifo_full;
   logic              fifo_empty;
   logic              rsp_ok;
   logic              spurious;
   logic              pop;
   logic              final_hs;
   logic              err_r;
   logic              done_r;

   // Requests in flight plus words already buffered must never exceed the FIFO.
   assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
   assign credit_ok   = (credit_used < DEPTH_C);

   assign rsp_ok   = rd_data_valid && (outstanding != '0);
   assign spurious = rd_data_valid && (outstanding == '0);
   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   assign final_hs  = pop && (out_cnt == BUF_LAST) && (state != IDLE);

   assign out_last = out_valid && (out_cnt == BUF_LAST);
   assign busy     = (state != IDLE);
   assign done     = done_r;
   assign err      = err_r;

   always_comb begin
      state_nxt = state;
      rd_en_in  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            rd_en_in = rd_rdy && (req_cnt < BUF_FULL) && credit_ok;
            if (rd_en_in && (req_cnt == BUF_LAST)) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            state_nxt = DRAIN;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (final_hs) begin
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         req_cnt     <= '0;
         out_cnt     <= '0;
         outstanding <= '0;
         err_r       <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_r <= final_hs;
         if ((state == IDLE) && start) begin
            req_cnt <= '0;
            out_cnt <= '0;
         end else begin
            if (rd_en_in) begin
               req_cnt <= req_cnt + RC_W'(1);
            end
            if (pop) begin
               out_cnt <= out_cnt + RC_W'(1);
            end
         end
         case ({rd_en_in, rsp_ok})
            2'b10:   outstanding <= outstanding + FC_W'(1);
            2'b01:   outstanding <= outstanding - FC_W'(1);
            default: outstanding <= outstanding;
         endcase
         if (spurious || (rsp_ok && fifo_full)) begin
            err_r <= 1'b1;
         end
      end
   end

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (rsp_ok),
      .push_data (rd_data),
      .pop       (pop),
      .pop_data  (out_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

`default_nettype wire

// File: tb/tb_frame_rd_stream.sv
// ---------------------------------------------------------------------------
// tb_frame_rd_stream : directed frame scenarios against a 2-cycle memory model (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_frame_rd_stream;

   localparam int DW = 32;
   localparam int BS = 5;
   localparam int FD = 4;

   typedef struct {
      logic [DW-1:0] base;
      bit            rdy_tog;
      bit            ordy_tog;
      bit            start_again;
      int            exp_req;
      int            exp_done;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          rd_rdy;
   logic          rd_en_in;
   logic          rd_data_valid;
   logic [DW-1:0] rd_data;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic          busy;
   logic          done;
   logic          err;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int n_req, n_hs, n_done, bad_req, unstable;
   int last_hs_cyc, done_cyc, first_rsp_cyc, first_ov_cyc;
   logic [DW-1:0] hs_data [8];
   logic          hs_last [8];
   logic          pv0, pv1;
   logic [DW-1:0] pd0, pd1, word_ctr;
   logic          prev_stall;
   logic [DW-1:0] prev_data;

   frame_rd_stream #(
      .DATA_WIDTH (DW),
      .BUF_SIZE   (BS),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .rd_rdy        (rd_rdy),
      .rd_en_in      (rd_en_in),
      .rd_data_valid (rd_data_valid),
      .rd_data       (rd_data),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_last      (out_last),
      .busy          (busy),
      .done          (done),
      .err           (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: sample outputs with inputs settled, then advance the memory pipe.
   task automatic tick();
      logic en;
      #1;
      if (rd_en_in) n_req++;
      if (rd_en_in && !rd_rdy) bad_req++;
      if (rd_data_valid && first_rsp_cyc < 0) first_rsp_cyc = cyc;
      if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (prev_stall && (!out_valid || out_data !== prev_data)) unstable++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
         if (n_hs < 8) begin
            hs_data[n_hs] = out_data;
            hs_last[n_hs] = out_last;
         end
         n_hs++;
         last_hs_cyc = cyc;
      end
      if (done) begin
         n_done++;
         done_cyc = cyc;
      end
      en = rd_en_in;
      @(posedge clk);
      #1;
      pv1 = pv0;
      pd1 = pd0;
      pv0 = en;
      pd0 = en ? word_ctr : '0;
      if (en) word_ctr++;
      rd_data_valid = pv1;
      rd_data       = pd1;
      cyc++;
   endtask

   task automatic clear_stats(input logic [DW-1:0] base);
      n_req = 0; n_hs = 0; n_done = 0; bad_req = 0; unstable = 0;
      last_hs_cyc = -1; done_cyc = -1; first_rsp_cyc = -1; first_ov_cyc = -1;
      word_ctr = base;
      prev_stall = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      tick();
      reset = 1'b0;
      pv0 = 1'b0; pv1 = 1'b0; pd0 = '0; pd1 = '0;
      rd_data_valid = 1'b0;
      rd_data       = '0;
      prev_stall    = 1'b0;
   endtask

   task automatic chk_reset_outs(input string name);
      #1;
      chk({name, "_ctl"}, {rd_en_in, out_valid, out_last, busy, done, err}, 6'b0);
      chk({name, "_data"}, out_data, '0);
   endtask

   task automatic run_frame(input int id, input vec_t v, input bit skip_start, input bit chain);
      int t;
      clear_stats(v.base);
      rd_rdy    = 1'b1;
      out_ready = 1'b1;
      if (!skip_start) begin
         start = 1'b1;
         tick();
         start = 1'b0;
      end
      t = 0;
      while (n_hs < BS && t < 200) begin
         rd_rdy    = v.rdy_tog ? cyc[0] : 1'b1;
         out_ready = v.ordy_tog ? ~cyc[0] : 1'b1;
         start     = v.start_again && (t == 2);
         tick();
         t++;
      end
      start = 1'b0;
      chk($sformatf("f%0d_no_timeout", id), t < 200, 1);
      rd_rdy    = 1'b1;
      out_ready = 1'b1;
      if (chain) start = 1'b1;
      tick();
      start = 1'b0;
      chk($sformatf("f%0d_done_timing", id), done_cyc, last_hs_cyc + 1);
      chk($sformatf("f%0d_busy_after", id), busy, chain);
      if (!chain) repeat (4) tick();
      chk($sformatf("f%0d_req_count", id), n_req, v.exp_req);
      chk($sformatf("f%0d_words", id), n_hs, BS);
      chk($sformatf("f%0d_done_count", id), n_done, v.exp_done);
      chk($sformatf("f%0d_err", id), err, 0);
      chk($sformatf("f%0d_req_without_rdy", id), bad_req, 0);
      chk($sformatf("f%0d_stall_stable", id), unstable, 0);
      chk($sformatf("f%0d_rsp_to_valid", id), first_ov_cyc - first_rsp_cyc, 1);
      for (int i = 0; i < BS; i++) begin
         chk($sformatf("f%0d_data%0d", id, i), hs_data[i], v.base + DW'(i));
         chk($sformatf("f%0d_last%0d", id, i), hs_last[i], (i == BS - 1));
      end
   endtask

   initial begin
      vec_t vecs [5];
      vec_t cv;
      int   t;

      vecs[0] = '{base: 32'h0000_0001, rdy_tog: 0, ordy_tog: 0, start_again: 0, exp_req: 5, exp_done: 1};
      vecs[1] = '{base: 32'h0000_0100, rdy_tog: 1, ordy_tog: 0, start_again: 0, exp_req: 5, exp_done: 1};
      vecs[2] = '{base: 32'hDEAD_BEE0, rdy_tog: 0, ordy_tog: 1, start_again: 0, exp_req: 5, exp_done: 1};
      vecs[3] = '{base: 32'h0000_2000, rdy_tog: 0, ordy_tog: 0, start_again: 1, exp_req: 5, exp_done: 1};
      vecs[4] = '{base: 32'h0000_000A, rdy_tog: 1, ordy_tog: 1, start_again: 0, exp_req: 5, exp_done: 1};

      reset = 1'b1; start = 1'b0; rd_rdy = 1'b0; out_ready = 1'b0;
      rd_data_valid = 1'b0; rd_data = '0;
      pv0 = 1'b0; pv1 = 1'b0; pd0 = '0; pd1 = '0;
      clear_stats('0);
      tick();
      do_reset();
      chk_reset_outs("reset_init");

      for (int i = 0; i < 5; i++) begin
         run_frame(i, vecs[i], 1'b0, 1'b0);
      end

      // Start coincident with done, then a back-to-back frame.
      cv = '{base: 32'h0000_0300, rdy_tog: 0, ordy_tog: 0, start_again: 0, exp_req: 5, exp_done: 1};
      run_frame(10, cv, 1'b0, 1'b1);
      cv.base = 32'h0000_0310;
      run_frame(11, cv, 1'b1, 1'b0);

      // Consumer stalled: credit limit holds requests at FIFO depth.
      clear_stats(32'h40);
      rd_rdy = 1'b1; out_ready = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (30) tick();
      chk("stall_req", n_req, FD);
      chk("stall_valid", out_valid, 1);
      chk("stall_head", out_data, 32'h40);
      chk("stall_last", out_last, 0);
      chk("stall_hs", n_hs, 0);
      out_ready = 1'b1;
      t = 0;
      while (n_hs < BS && t < 100) begin tick(); t++; end
      tick();
      chk("stall_no_timeout", t < 100, 1);
      chk("stall_req_total", n_req, BS);
      chk("stall_words", n_hs, BS);
      chk("stall_final", hs_data[BS-1], 32'h44);
      chk("stall_final_last", hs_last[BS-1], 1);
      chk("stall_done", n_done, 1);
      chk("stall_unstable", unstable, 0);

      // Reset after the third handshake, then a clean frame.
      clear_stats(32'h70);
      rd_rdy = 1'b1; out_ready = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      t = 0;
      while (n_hs < 3 && t < 100) begin tick(); t++; end
      chk("midreset_reached", n_hs, 3);
      do_reset();
      chk_reset_outs("midreset");
      cv = '{base: 32'h0000_0080, rdy_tog: 0, ordy_tog: 0, start_again: 0, exp_req: 5, exp_done: 1};
      run_frame(20, cv, 1'b0, 1'b0);

      // Spurious response while idle: err is sticky until reset.
      pv0 = 1'b1; pd0 = 32'h55;
      tick();
      tick();
      chk("spur_err", err, 1);
      chk("spur_valid", out_valid, 0);
      repeat (5) tick();
      chk("spur_err_sticky", err, 1);
      chk("spur_valid_later", out_valid, 0);
      chk("spur_busy", busy, 0);
      do_reset();
      chk_reset_outs("spur_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/frame_rd_stream.md
FRAME_RD_STREAM -- requirements
Module: frame_rd_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning width of memory read data and output stream.
REQ-002 SHALL have parameter BUF_SIZE, default 5, meaning words per frame read.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2), meaning internal prefetch FIFO entries.
REQ-004 SHALL use one clock; reset is synchronous and active-high; ports named clk and reset.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 start  input  1  single-cycle request to read one frame.
REQ-008 rd_rdy  input  1  memory can accept a read request this cycle.
REQ-009 rd_en_in  output  1  one-cycle read request to the frame buffer (one word per assertion).
REQ-010 rd_data_valid  input  1  rd_data carries a returned word this cycle.
REQ-011 rd_data  input  DATA_WIDTH  returned memory word.
REQ-012 out_data  output  DATA_WIDTH  stream word (FIFO head).
REQ-013 out_valid  output  1  out_data valid.
REQ-014 out_ready  input  1  consumer accepts word when out_valid and out_ready both high.
REQ-015 out_last  output  1  high with out_valid on the frame's final word.
REQ-016 busy  output  1  high when not in IDLE.
REQ-017 done  output  1  one-cycle pulse after final word handshake.
REQ-018 err  output  1  sticky: response received with zero outstanding requests, or FIFO push while full.

Function
REQ-019 SHALL implement states IDLE, FETCH, DRAIN.
REQ-020 IDLE->FETCH on start; req_cnt, out_cnt cleared; start ignored in FETCH/DRAIN.
REQ-021 In FETCH, rd_en_in SHALL be high in a cycle iff rd_rdy=1, req_cnt<BUF_SIZE, and outstanding+fifo_count<FIFO_DEPTH (credit check, using registered values).
REQ-022 Each rd_en_in cycle increments req_cnt and outstanding; each rd_data_valid decrements outstanding; simultaneous request and response leave outstanding unchanged.
REQ-023 FETCH->DRAIN on the cycle req_cnt reaches BUF_SIZE; rd_en_in never asserted outside FETCH.
REQ-024 rd_data_valid with outstanding>0 SHALL push rd_data; with outstanding=0 data dropped and err set.
REQ-025 FIFO registered: word pushed at edge N visible on out_data/out_valid from cycle N+1; response-to-out_valid latency exactly 1 cycle when FIFO empty.
REQ-026 Simultaneous push and pop SHALL keep fifo_count unchanged; push when full (impossible under REQ-021) sets err and drops word.
REQ-027 out_valid = fifo_count!=0; out_data stable while out_valid && !out_ready.
REQ-028 out_last = out_valid && out_cnt==BUF_SIZE-1; out_cnt increments per handshake.
REQ-029 Final handshake: state->IDLE, done pulses high the following cycle for exactly one cycle, FIFO empty, outstanding 0.
REQ-030 Counters sized $clog2(BUF_SIZE+1) and $clog2(FIFO_DEPTH+1); FIFO pointers wrap modulo FIFO_DEPTH.
REQ-031 start coincident with done SHALL be accepted (IDLE that cycle).

Reset
REQ-032 Reset SHALL override all activity including mid-frame: state IDLE, counters, outstanding, FIFO pointers, err zero.
REQ-033 Reset values: rd_en_in=0, out_valid=0, out_last=0, busy=0, done=0, err=0, out_data=0.

Structure
REQ-034 Shared package frame_buf_pkg SHALL hold state enum (IDLE/FETCH/DRAIN) and default DATA_WIDTH/BUF_SIZE constants common with frame_buf_alt.
REQ-035 FIFO SHALL be sub-module sync_fifo (DATA_WIDTH, FIFO_DEPTH, push/pop/count/full/empty); top holds FSM and credit logic.

Verification
REQ-036 Start, rd_rdy=1, fixed 2-cycle memory latency, out_ready=1, words 1..5 -> out_data 1,2,3,4,5 in order, out_last only on 5, done once, err=0.
REQ-037 out_ready=0 throughout -> exactly 4 rd_en_in pulses, out_valid high holding word 1, no further requests until out_ready rises.
REQ-038 rd_rdy toggling 1/0 each cycle -> rd_en_in only in rd_rdy=1 cycles, total 5 requests, all 5 words delivered.
REQ-039 Spurious rd_data_valid in IDLE -> err=1, out_valid stays 0, err remains set until reset.
REQ-040 Reset asserted after 3rd handshake -> next cycle all outputs at reset values; new start reads full 5-word frame from out_cnt 0.
REQ-041 start pulsed during FETCH -> ignored; only 5 requests issued, single done.
